xge_pkt_rx_drain: RTL and testbench

//  Synthesizable reader for the xge_mac packet-receive interface: drains frames whenever pkt_rx_avail is high.

---
 rtl/xge_pkt_rx_drain.sv | 149 ++++++++++++++
 tb/tb_xge_pkt_rx_drain.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/xge_pkt_rx_drain.sv
// Drains frames from the xge_mac pkt_rx_* interface, checks SOP/EOP framing and keeps frame statistics.
// Optional payload sequence checking is built when XGE_RX_SEQ_CHECK_EN is defined.
module xge_pkt_rx_drain #(
  parameter int CNT_W   = 32,
  parameter int LEN_W   = 16,
  parameter int MAX_LEN = 1518
) (
  input  logic             clk_156m25,
  input  logic             reset_156m25_n,
  input  logic             pkt_rx_avail,
  output logic             pkt_rx_ren,
  input  logic             pkt_rx_val,
  input  logic             pkt_rx_sop,
  input  logic             pkt_rx_eop,
  input  logic [2:0]       pkt_rx_mod,
  input  logic             pkt_rx_err,
  input  logic [63:0]      pkt_rx_data,
  input  logic             clr_stats,
  output logic             busy,
  output logic             len_vld,
  output logic [LEN_W-1:0] last_len,
  output logic [CNT_W-1:0] pkt_cnt,
  output logic [CNT_W-1:0] byte_cnt,
  output logic [CNT_W-1:0] err_cnt,
  output logic [CNT_W-1:0] frm_err_cnt,
  output logic [CNT_W-1:0] ovs_cnt,
  output logic [CNT_W-1:0] seq_err_cnt
);

  typedef enum logic [1:0] {IDLE, READ, FLUSH} state_t;

  localparam logic [LEN_W-1:0] MAX_LEN_L = LEN_W'(MAX_LEN);

  state_t           state, state_nxt;
  logic             frm_open;
  logic [LEN_W-1:0] len_acc;

  logic [3:0]       beat_bytes;
  logic [LEN_W:0]   len_sum;
  logic [LEN_W-1:0] len_new;
  logic             accept;
  logic             frm_viol;
  logic             closing;

  // NOTE: asynchronous active-low reset; every register below lists it in the sensitivity list.
  always_ff @(posedge clk_156m25 or negedge reset_156m25_n) begin
    if (!reset_156m25_n) state <= IDLE;
    else                 state <= state_nxt;
  end

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (pkt_rx_avail) state_nxt = READ;
      READ:    if (pkt_rx_val && pkt_rx_eop) state_nxt = FLUSH;
      FLUSH:   state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  assign pkt_rx_ren = (state == READ);
  assign busy       = (state != IDLE);

  // Beat decode; FLUSH is one cycle long, so it can absorb at most one in-flight beat.
  always_comb begin
    beat_bytes = (pkt_rx_eop && pkt_rx_mod != 3'd0) ? {1'b0, pkt_rx_mod} : 4'd8;
    accept     = pkt_rx_val && (state != IDLE);
    len_sum    = (pkt_rx_sop ? '0 : {1'b0, len_acc}) + (LEN_W+1)'(beat_bytes);
    len_new    = len_sum[LEN_W] ? '1 : len_sum[LEN_W-1:0];
    closing    = accept && pkt_rx_eop && (pkt_rx_sop || frm_open);
    frm_viol   = (pkt_rx_val && state == IDLE)
              || (accept &&  pkt_rx_sop &&  frm_open)
              || (accept && !pkt_rx_sop && !frm_open);
  end

  // NOTE: sequential state uses non-blocking assignments only, so every register sees pre-edge values.
  always_ff @(posedge clk_156m25 or negedge reset_156m25_n) begin
    if (!reset_156m25_n) begin
      frm_open <= 1'b0;
      len_acc  <= '0;
      last_len <= '0;
      len_vld  <= 1'b0;
    end else begin
      len_vld <= closing;
      if (accept && (pkt_rx_sop || frm_open)) begin
        frm_open <= !pkt_rx_eop;
        len_acc  <= len_new;
      end
      if (closing) last_len <= len_new;
    end
  end

  // Statistics: clr_stats wins over any same-cycle increment.
  always_ff @(posedge clk_156m25 or negedge reset_156m25_n) begin
    if (!reset_156m25_n) begin
      pkt_cnt     <= '0;
      byte_cnt    <= '0;
      err_cnt     <= '0;
      frm_err_cnt <= '0;
      ovs_cnt     <= '0;
    end else if (clr_stats) begin
      pkt_cnt     <= '0;
      byte_cnt    <= '0;
      err_cnt     <= '0;
      frm_err_cnt <= '0;
      ovs_cnt     <= '0;
    end else begin
      if (closing) begin
        pkt_cnt  <= pkt_cnt + CNT_W'(1);
        byte_cnt <= byte_cnt + CNT_W'(len_new);
        err_cnt  <= err_cnt + CNT_W'(pkt_rx_err);
        if (len_new > MAX_LEN_L) ovs_cnt <= ovs_cnt + CNT_W'(1);
      end
      if (frm_viol) frm_err_cnt <= frm_err_cnt + CNT_W'(1);
    end
  end

`ifdef XGE_RX_SEQ_CHECK_EN
  logic [63:0] seq_exp;
  logic [63:0] seq_mask;
  logic        seq_miss;

  // Only the valid bytes of an EOP beat take part in the comparison, LSB-first.
  always_comb begin
    seq_mask = '0;
    for (int b = 0; b < 8; b++) seq_mask[8*b +: 8] = {8{4'(b) < beat_bytes}};
    seq_miss = accept && !pkt_rx_sop && frm_open
            && (((pkt_rx_data ^ seq_exp) & seq_mask) != 64'd0);
  end

  // Expectation always follows the received data, which also re-seeds it after a mismatch.
  always_ff @(posedge clk_156m25 or negedge reset_156m25_n) begin
    if (!reset_156m25_n) begin
      seq_exp     <= '0;
      seq_err_cnt <= '0;
    end else begin
      if (accept && (pkt_rx_sop || frm_open)) seq_exp <= pkt_rx_data + 64'd1;
      if (clr_stats)     seq_err_cnt <= '0;
      else if (seq_miss) seq_err_cnt <= seq_err_cnt + CNT_W'(1);
    end
  end
`else
  logic data_unused;
  assign data_unused = ^pkt_rx_data;
  assign seq_err_cnt = '0;
`endif

endmodule

// File: tb/tb_xge_pkt_rx_drain.sv
// Directed self-checking bench for xge_pkt_rx_drain with a small ren-driven MAC model.
`timescale 1ns/1ps
module tb_xge_pkt_rx_drain;
  localparam int CNT_W   = 32;
  localparam int LEN_W   = 16;
  localparam int MAX_LEN = 64;
  localparam int BUDGET  = 500;

  logic             clk_156m25 = 1'b0;
  logic             reset_156m25_n = 1'b0;
  logic             pkt_rx_avail = 1'b0;
  logic             pkt_rx_ren;
  logic             pkt_rx_val = 1'b0;
  logic             pkt_rx_sop = 1'b0;
  logic             pkt_rx_eop = 1'b0;
  logic [2:0]       pkt_rx_mod = 3'd0;
  logic             pkt_rx_err = 1'b0;
  logic [63:0]      pkt_rx_data = 64'd0;
  logic             clr_stats = 1'b0;
  logic             busy;
  logic             len_vld;
  logic [LEN_W-1:0] last_len;
  logic [CNT_W-1:0] pkt_cnt, byte_cnt, err_cnt, frm_err_cnt, ovs_cnt, seq_err_cnt;

  always #3 clk_156m25 = ~clk_156m25;

  xge_pkt_rx_drain #(.CNT_W(CNT_W), .LEN_W(LEN_W), .MAX_LEN(MAX_LEN)) dut (
    .clk_156m25     (clk_156m25),
    .reset_156m25_n (reset_156m25_n),
    .pkt_rx_avail   (pkt_rx_avail),
    .pkt_rx_ren     (pkt_rx_ren),
    .pkt_rx_val     (pkt_rx_val),
    .pkt_rx_sop     (pkt_rx_sop),
    .pkt_rx_eop     (pkt_rx_eop),
    .pkt_rx_mod     (pkt_rx_mod),
    .pkt_rx_err     (pkt_rx_err),
    .pkt_rx_data    (pkt_rx_data),
    .clr_stats      (clr_stats),
    .busy           (busy),
    .len_vld        (len_vld),
    .last_len       (last_len),
    .pkt_cnt        (pkt_cnt),
    .byte_cnt       (byte_cnt),
    .err_cnt        (err_cnt),
    .frm_err_cnt    (frm_err_cnt),
    .ovs_cnt        (ovs_cnt),
    .seq_err_cnt    (seq_err_cnt)
  );

  typedef struct packed {
    logic        sop;
    logic        eop;
    logic [2:0]  mod;
    logic        err;
    logic [63:0] data;
  } beat_t;

  beat_t q[$];
  int    n_checks = 0;
  int    n_fail   = 0;
  int    vld_pulses;
  int    ren_lag;
`ifdef XGE_RX_SEQ_CHECK_EN
  localparam int SEQ_EXP = 1;
`else
  localparam int SEQ_EXP = 0;
`endif

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual=%0d expected=%0d", tag, act, exp);
    end
  endtask

  function automatic beat_t mk(input logic sop, input logic eop, input logic [2:0] mod,
                               input logic err, input logic [63:0] data);
    beat_t b;
    b.sop = sop; b.eop = eop; b.mod = mod; b.err = err; b.data = data;
    return b;
  endfunction

  // Pushes an n-beat frame with data base, base+1, ...; last beat carries mod/err.
  task automatic push_frame(input int n, input logic [2:0] mod, input logic err, input logic [63:0] base);
    for (int i = 0; i < n; i++)
      q.push_back(mk(i == 0, i == n-1, (i == n-1) ? mod : 3'd0, (i == n-1) ? err : 1'b0, base + 64'(i)));
  endtask

  task automatic drive_idle();
    pkt_rx_val = 1'b0; pkt_rx_sop = 1'b0; pkt_rx_eop = 1'b0;
    pkt_rx_mod = 3'd0; pkt_rx_err = 1'b0; pkt_rx_data = 64'd0;
  endtask

  // MAC model: a beat appears one cycle after each ren cycle while the queue has data.
  task automatic run_mac(input bit clr_on_eop);
    int  fetched = 0;
    int  cyc = 0;
    int  tail = 0;
    int  avail_cyc = -1;
    int  ren_cyc = -1;
    bit  prev_ren = 1'b0;
    vld_pulses = 0;
    while (tail < 4 && cyc < BUDGET) begin
      @(negedge clk_156m25);
      cyc++;
      clr_stats = 1'b0;
      if (prev_ren && fetched < q.size()) begin
        pkt_rx_val  = 1'b1;
        pkt_rx_sop  = q[fetched].sop;
        pkt_rx_eop  = q[fetched].eop;
        pkt_rx_mod  = q[fetched].mod;
        pkt_rx_err  = q[fetched].err;
        pkt_rx_data = q[fetched].data;
        if (clr_on_eop && q[fetched].eop) clr_stats = 1'b1;
        fetched++;
      end else begin
        drive_idle();
      end
      prev_ren     = pkt_rx_ren;
      pkt_rx_avail = (fetched < q.size());
      if (pkt_rx_avail && avail_cyc < 0) avail_cyc = cyc;
      if (pkt_rx_ren && ren_cyc < 0)     ren_cyc = cyc;
      if (len_vld) vld_pulses++;
      if (fetched == q.size()) tail++;
    end
    drive_idle();
    clr_stats    = 1'b0;
    pkt_rx_avail = 1'b0;
    ren_lag = (avail_cyc >= 0 && ren_cyc >= 0) ? ren_cyc - avail_cyc : -1;
    check("mac_budget", 64'(cyc < BUDGET), 64'd1);
    q.delete();
  endtask

  task automatic do_reset();
    drive_idle();
    pkt_rx_avail = 1'b0;
    clr_stats = 1'b0;
    @(negedge clk_156m25);
    reset_156m25_n = 1'b0;
    repeat (2) @(negedge clk_156m25);
    reset_156m25_n = 1'b1;
    @(negedge clk_156m25);
  endtask

  task automatic check_all_zero(input string pfx);
    check({pfx, "_ren"},      64'(pkt_rx_ren),  64'd0);
    check({pfx, "_busy"},     64'(busy),        64'd0);
    check({pfx, "_len_vld"},  64'(len_vld),     64'd0);
    check({pfx, "_last_len"}, 64'(last_len),    64'd0);
    check({pfx, "_pkt"},      64'(pkt_cnt),     64'd0);
    check({pfx, "_byte"},     64'(byte_cnt),    64'd0);
    check({pfx, "_err"},      64'(err_cnt),     64'd0);
    check({pfx, "_frm"},      64'(frm_err_cnt), 64'd0);
    check({pfx, "_ovs"},      64'(ovs_cnt),     64'd0);
    check({pfx, "_seq"},      64'(seq_err_cnt), 64'd0);
  endtask

  initial begin
    // Reset state, observed while reset is held
    repeat (2) @(negedge clk_156m25);
    check_all_zero("rst");

    // 1: 8-beat frame, mod=4 -> 7*8+4 = 60 bytes
    do_reset();
    push_frame(8, 3'd4, 1'b0, 64'd100);
    run_mac(1'b0);
    check("t1_ren_lag",  64'(ren_lag),    64'd1);
    check("t1_last_len", 64'(last_len),   64'd60);
    check("t1_pkt",      64'(pkt_cnt),    64'd1);
    check("t1_byte",     64'(byte_cnt),   64'd60);
    check("t1_vld",      64'(vld_pulses), 64'd1);
    check("t1_frm",      64'(frm_err_cnt), 64'd0);
    check("t1_busy",     64'(busy),       64'd0);

    // 2: single beat sop=eop, mod=0 (8 bytes), err=1
    do_reset();
    q.push_back(mk(1'b1, 1'b1, 3'd0, 1'b1, 64'd7));
    run_mac(1'b0);
    check("t2_last_len", 64'(last_len), 64'd8);
    check("t2_pkt",      64'(pkt_cnt),  64'd1);
    check("t2_err",      64'(err_cnt),  64'd1);
    check("t2_byte",     64'(byte_cnt), 64'd8);

    // 3: 3 beats of an open frame, then a new SOP starting a 2-beat frame (16 bytes)
    do_reset();
    push_frame(3, 3'd0, 1'b0, 64'd0);
    void'(q.pop_back());
    q.push_back(mk(1'b0, 1'b0, 3'd0, 1'b0, 64'd2));
    push_frame(2, 3'd0, 1'b0, 64'd20);
    run_mac(1'b0);
    check("t3_frm",      64'(frm_err_cnt), 64'd1);
    check("t3_pkt",      64'(pkt_cnt),     64'd1);
    check("t3_last_len", 64'(last_len),    64'd16);
    check("t3_byte",     64'(byte_cnt),    64'd16);

    // 4: 64-byte frame (at MAX_LEN) back-to-back with a 72-byte frame; second SOP lands in FLUSH
    do_reset();
    push_frame(8, 3'd0, 1'b0, 64'd0);
    push_frame(9, 3'd0, 1'b0, 64'd50);
    run_mac(1'b0);
    check("t4_ovs",      64'(ovs_cnt),     64'd1);
    check("t4_last_len", 64'(last_len),    64'd72);
    check("t4_pkt",      64'(pkt_cnt),     64'd2);
    check("t4_byte",     64'(byte_cnt),    64'd136);
    check("t4_frm",      64'(frm_err_cnt), 64'd0);
    check("t4_vld",      64'(vld_pulses),  64'd2);

    // 5: reset in the middle of an open frame, then a clean 2-beat frame
    do_reset();
    push_frame(3, 3'd0, 1'b0, 64'd0);
    void'(q.pop_back());
    q.push_back(mk(1'b0, 1'b0, 3'd0, 1'b0, 64'd2));
    run_mac(1'b0);
    check("t5_busy_pre", 64'(busy), 64'd1);
    reset_156m25_n = 1'b0;
    @(negedge clk_156m25);
    check_all_zero("t5_rst");
    reset_156m25_n = 1'b1;
    @(negedge clk_156m25);
    push_frame(2, 3'd0, 1'b0, 64'd30);
    run_mac(1'b0);
    check("t5_pkt",      64'(pkt_cnt),     64'd1);
    check("t5_frm",      64'(frm_err_cnt), 64'd0);
    check("t5_last_len", 64'(last_len),    64'd16);

    // 6: payload 5,6,9,10 -> one sequence error; then a frame whose EOP differs only above mod=2 bytes
    do_reset();
    q.push_back(mk(1'b1, 1'b0, 3'd0, 1'b0, 64'd5));
    q.push_back(mk(1'b0, 1'b0, 3'd0, 1'b0, 64'd6));
    q.push_back(mk(1'b0, 1'b0, 3'd0, 1'b0, 64'd9));
    q.push_back(mk(1'b0, 1'b1, 3'd0, 1'b0, 64'd10));
    q.push_back(mk(1'b1, 1'b0, 3'd0, 1'b0, 64'h100));
    q.push_back(mk(1'b0, 1'b1, 3'd2, 1'b0, 64'hABCD_0000_0000_0101));
    run_mac(1'b0);
    check("t6_seq",      64'(seq_err_cnt), 64'(SEQ_EXP));
    check("t6_pkt",      64'(pkt_cnt),     64'd2);
    check("t6_byte",     64'(byte_cnt),    64'd42);
    check("t6_last_len", 64'(last_len),    64'd10);

    // 7: clr_stats coincident with an EOP clears every counter but not last_len
    do_reset();
    push_frame(2, 3'd0, 1'b1, 64'd0);
    q.push_back(mk(1'b1, 1'b0, 3'd0, 1'b0, 64'd40));
    q.push_back(mk(1'b0, 1'b1, 3'd3, 1'b0, 64'd99));
    run_mac(1'b1);
    check("t7_pkt",      64'(pkt_cnt),     64'd0);
    check("t7_byte",     64'(byte_cnt),    64'd0);
    check("t7_err",      64'(err_cnt),     64'd0);
    check("t7_frm",      64'(frm_err_cnt), 64'd0);
    check("t7_ovs",      64'(ovs_cnt),     64'd0);
    check("t7_seq",      64'(seq_err_cnt), 64'd0);
    check("t7_last_len", 64'(last_len),    64'd11);
    push_frame(2, 3'd0, 1'b0, 64'd60);
    run_mac(1'b0);
    check("t7_pkt_after",  64'(pkt_cnt),  64'd1);
    check("t7_byte_after", 64'(byte_cnt), 64'd16);

    // 8: a valid beat while IDLE is a framing violation and is ignored
    do_reset();
    @(negedge clk_156m25);
    pkt_rx_val = 1'b1; pkt_rx_sop = 1'b1; pkt_rx_eop = 1'b1; pkt_rx_data = 64'd1;
    @(negedge clk_156m25);
    drive_idle();
    @(negedge clk_156m25);
    check("t8_frm",  64'(frm_err_cnt), 64'd1);
    check("t8_pkt",  64'(pkt_cnt),     64'd0);
    check("t8_busy", 64'(busy),        64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
